// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg : FSM encoding, clog2 helper and shared lane/pixel/RAM defaults
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package image_pkg;

  localparam int CH_DEFAULT    = 8;
  localparam int PIX_W_DEFAULT = 10;
  localparam int RAM_W_DEFAULT = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SERIAL = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/image_lane_mux.sv
// ---------------------------------------------------------------------------
// image_lane_mux : registered CH:1 lane selector, PIX_W bits per lane
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module image_lane_mux
  import image_pkg::*;
#(
  parameter int CH    = CH_DEFAULT,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [clog2(CH)-1:0]  sel,
  input  logic [CH*PIX_W-1:0]   lanes,
  output logic [PIX_W-1:0]      pix
);

  logic [PIX_W-1:0] lane_arr [CH];

  for (genvar g = 0; g < CH; g++) begin : g_lane
    assign lane_arr[g] = lanes[g*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix <= '0;
    end else if (en) begin
      pix <= lane_arr[sel];
    end
  end

endmodule

`default_nettype wire

// File: rtl/image_ram_writer.sv
// ---------------------------------------------------------------------------
// image_ram_writer : serialises CH-lane CMOS beats into ping-pong line-RAM writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module image_ram_writer
  import image_pkg::*;
#(
  parameter int CH          = CH_DEFAULT,
  parameter int PIX_W       = PIX_W_DEFAULT,
  parameter int RAM_W       = RAM_W_DEFAULT,
  parameter int ADDR_W      = 8,
  parameter bit MIRROR_EVEN = 1'b1
) (
  input  logic                clk_cmos,
  input  logic                rst_n,
  input  logic                frame,
  input  logic                training_pattern,
  input  logic                cmos_data_pulse,
  input  logic [CH*PIX_W-1:0] image_data,
  output logic [RAM_W-1:0]    ram_wdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [1:0]          ram_we,
  output logic                bank_swap_pulse,
  output logic                overflow,
  output logic                busy
);

  localparam int K_W  = clog2(CH);
  localparam int BC_W = ADDR_W - K_W;

  state_t              state;
  logic [K_W-1:0]      k;
  logic [CH*PIX_W-1:0] hold;
  logic                p;
  logic [BC_W-1:0]     bcnt;
  logic                bank;
  logic                beat_p;
  logic [BC_W-1:0]     beat_bcnt;
  logic                beat_bank;
  logic                last_word;
  logic [PIX_W-1:0]    pix;

  logic            pulse_ok;
  logic            last_k;
  logic            accept;
  logic            drop;
  logic [K_W-1:0]  j;

  assign pulse_ok = cmos_data_pulse & ~training_pattern & ~frame;
  assign last_k   = (state == ST_SERIAL) && (k == K_W'(CH - 1));
  assign accept   = pulse_ok & ((state == ST_IDLE) | last_k);
  assign drop     = pulse_ok & (state == ST_SERIAL) & ~last_k;
  // Even-parity beats land lane-reversed within their CH-word slot.
  assign j        = (MIRROR_EVEN && !beat_p) ? (K_W'(CH - 1) - k) : k;

  always_ff @(posedge clk_cmos or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      k               <= '0;
      hold            <= '0;
      p               <= 1'b0;
      bcnt            <= '0;
      bank            <= 1'b0;
      beat_p          <= 1'b0;
      beat_bcnt       <= '0;
      beat_bank       <= 1'b0;
      last_word       <= 1'b0;
      ram_addr        <= '0;
      ram_we          <= '0;
      bank_swap_pulse <= 1'b0;
      overflow        <= 1'b0;
      busy            <= 1'b0;
    end else if (frame) begin
      state           <= ST_IDLE;
      k               <= '0;
      p               <= 1'b0;
      bcnt            <= '0;
      bank            <= 1'b0;
      last_word       <= 1'b0;
      ram_we          <= '0;
      bank_swap_pulse <= 1'b0;
      overflow        <= 1'b0;
      busy            <= 1'b0;
    end else begin
      ram_we    <= '0;
      last_word <= 1'b0;
      if (state == ST_SERIAL) begin
        ram_we[beat_bank] <= 1'b1;
        ram_addr          <= {beat_bcnt, j};
        last_word         <= last_k && (&beat_bcnt);
      end
      bank_swap_pulse <= last_word;

      if (drop) overflow <= 1'b1;

      if (accept) begin
        hold      <= image_data;
        beat_p    <= p;
        beat_bcnt <= bcnt;
        beat_bank <= bank;
        p         <= ~p;
        bcnt      <= bcnt + BC_W'(1);
        if (&bcnt) bank <= ~bank;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_SERIAL;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SERIAL: begin
          if (last_k) begin
            k <= '0;
            if (!accept) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            k <= k + K_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  image_lane_mux #(
    .CH    (CH),
    .PIX_W (PIX_W)
  ) u_lane_mux (
    .clk   (clk_cmos),
    .rst_n (rst_n),
    .en    ((state == ST_SERIAL) && !frame),
    .sel   (k),
    .lanes (hold),
    .pix   (pix)
  );

  assign ram_wdata = RAM_W'(pix);

endmodule

`default_nettype wire

// File: tb/tb_image_ram_writer.sv
// ---------------------------------------------------------------------------
// tb_image_ram_writer : table-driven beats plus scoreboard of expected RAM writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_image_ram_writer;

  localparam int CH     = 8;
  localparam int PIX_W  = 10;
  localparam int RAM_W  = 16;
  localparam int ADDR_W = 8;
  localparam int BEATS_PER_BANK = (1 << ADDR_W) / CH;

  logic                clk_cmos = 1'b0;
  logic                rst_n = 1'b0;
  logic                frame = 1'b0;
  logic                training_pattern = 1'b0;
  logic                cmos_data_pulse = 1'b0;
  logic [CH*PIX_W-1:0] image_data = '0;
  logic [RAM_W-1:0]    ram_wdata;
  logic [ADDR_W-1:0]   ram_addr;
  logic [1:0]          ram_we;
  logic                bank_swap_pulse;
  logic                overflow;
  logic                busy;

  always #5 clk_cmos = ~clk_cmos;

  image_ram_writer #(
    .CH          (CH),
    .PIX_W       (PIX_W),
    .RAM_W       (RAM_W),
    .ADDR_W      (ADDR_W),
    .MIRROR_EVEN (1'b1)
  ) dut (
    .clk_cmos         (clk_cmos),
    .rst_n            (rst_n),
    .frame            (frame),
    .training_pattern (training_pattern),
    .cmos_data_pulse  (cmos_data_pulse),
    .image_data       (image_data),
    .ram_wdata        (ram_wdata),
    .ram_addr         (ram_addr),
    .ram_we           (ram_we),
    .bank_swap_pulse  (bank_swap_pulse),
    .overflow         (overflow),
    .busy             (busy)
  );

  typedef struct {
    int                cyc;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [RAM_W-1:0]  data;
  } wr_t;

  typedef struct {
    logic [PIX_W-1:0] base;
    bit               train;
    int               gap;
    logic             exp_ovf;
  } vec_t;

  wr_t exp_q[$];
  int  swap_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  // reference model state
  int  m_last = -1000;
  bit  m_p = 1'b0;
  int  m_bcnt = 0;
  bit  m_bank = 1'b0;

  always @(posedge clk_cmos) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_cmos) begin
    wr_t e;
    if (rst_n) begin
      if (ram_we != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", {30'd0, ram_we}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_we", {30'd0, ram_we}, {30'd0, e.we});
          check("wr_addr", {24'd0, ram_addr}, {24'd0, e.addr});
          check("wr_data", {16'd0, ram_wdata}, {16'd0, e.data});
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check("missed_wr", cyc, exp_q[0].cyc + 1000);
        void'(exp_q.pop_front());
      end
      if (swap_q.size() > 0 && swap_q[0] == cyc) begin
        check("swap_pulse", {31'd0, bank_swap_pulse}, 32'd1);
        void'(swap_q.pop_front());
      end else if (bank_swap_pulse) begin
        check("spurious_swap", {31'd0, bank_swap_pulse}, 32'd0);
      end
    end
  end

  task automatic model_reset();
    m_last = -1000;
    m_p    = 1'b0;
    m_bcnt = 0;
    m_bank = 1'b0;
  endtask

  task automatic model_pulse(input logic [PIX_W-1:0] base, input bit train);
    wr_t              e;
    int               j;
    logic [PIX_W-1:0] v;
    if (train) return;
    if (cyc - m_last < CH) return;
    m_last = cyc;
    for (int k = 0; k < CH; k++) begin
      j      = (m_p == 1'b0) ? (CH - 1 - k) : k;
      v      = base + PIX_W'(k);
      e.cyc  = cyc + 2 + k;
      e.we   = m_bank ? 2'b10 : 2'b01;
      e.addr = ADDR_W'(m_bcnt * CH + j);
      e.data = RAM_W'(v);
      exp_q.push_back(e);
    end
    m_p    = ~m_p;
    m_bcnt = (m_bcnt + 1) % BEATS_PER_BANK;
    if (m_bcnt == 0) begin
      swap_q.push_back(cyc + 2 + CH);
      m_bank = ~m_bank;
    end
  endtask

  // Called at a negedge; returns at the negedge gap cycles later.
  task automatic send(input logic [PIX_W-1:0] base, input bit train, input int gap);
    for (int k = 0; k < CH; k++) image_data[k*PIX_W +: PIX_W] = base + PIX_W'(k);
    cmos_data_pulse  = 1'b1;
    training_pattern = train;
    model_pulse(base, train);
    @(negedge clk_cmos);
    cmos_data_pulse  = 1'b0;
    training_pattern = 1'b0;
    repeat (gap - 1) @(negedge clk_cmos);
  endtask

  task automatic do_frame();
    frame = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    while (swap_q.size() > 0 && swap_q[$] > cyc) void'(swap_q.pop_back());
    model_reset();
    @(negedge clk_cmos);
    frame = 1'b0;
    check("ovf_after_frame", {31'd0, overflow}, 32'd0);
  endtask

  task automatic drain();
    repeat (2 * CH + 4) @(negedge clk_cmos);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  vec_t vecs[7];
  int   c0;

  initial begin
    vecs[0] = '{base: 10'h001, train: 1'b0, gap: 12, exp_ovf: 1'b0};
    vecs[1] = '{base: 10'h011, train: 1'b0, gap: 12, exp_ovf: 1'b0};
    vecs[2] = '{base: 10'h100, train: 1'b0, gap: 8,  exp_ovf: 1'b0};
    vecs[3] = '{base: 10'h200, train: 1'b0, gap: 3,  exp_ovf: 1'b0};
    vecs[4] = '{base: 10'h300, train: 1'b0, gap: 12, exp_ovf: 1'b1};
    vecs[5] = '{base: 10'h3FF, train: 1'b1, gap: 12, exp_ovf: 1'b1};
    vecs[6] = '{base: 10'h2AA, train: 1'b0, gap: 12, exp_ovf: 1'b1};

    repeat (3) @(negedge clk_cmos);
    check("rst_we", {30'd0, ram_we}, 32'd0);
    check("rst_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_data", {16'd0, ram_wdata}, 32'd0);
    check("rst_swap", {31'd0, bank_swap_pulse}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_cmos);

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].base, vecs[i].train, vecs[i].gap);
      check("vec_ovf", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end
    drain();

    // busy window: high from T+1 through T+CH
    do_frame();
    c0 = cyc;
    send(10'h0F0, 1'b0, 1);
    check("busy_first", {31'd0, busy}, 32'd1);
    repeat (CH - 1) @(negedge clk_cmos);
    check("busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk_cmos);
    check("busy_drop", {31'd0, busy}, 32'd0);
    check("busy_window", cyc - c0, CH + 1);
    drain();

    // full bank plus one beat, back to back
    do_frame();
    for (int i = 0; i <= BEATS_PER_BANK; i++) send(PIX_W'(i * 8), 1'b0, CH);
    drain();
    check("swap_q_empty", swap_q.size(), 32'd0);

    // dropped beat, sticky overflow, frame clears and restarts at bank 0
    send(10'h123, 1'b0, 3);
    send(10'h155, 1'b0, 10);
    for (int i = 0; i < 3; i++) begin
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      @(negedge clk_cmos);
    end
    do_frame();
    send(10'h0AA, 1'b0, 12);
    drain();

    // frame during word 4 aborts the beat
    send(10'h040, 1'b0, 6);
    do_frame();
    repeat (12) @(negedge clk_cmos);
    send(10'h2C0, 1'b0, 12);
    drain();

    // asynchronous reset mid-beat
    send(10'h300, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    check("arst_we", {30'd0, ram_we}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_data", {16'd0, ram_wdata}, 32'd0);
    exp_q.delete();
    swap_q.delete();
    model_reset();
    @(negedge clk_cmos);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_cmos);
    send(10'h1E0, 1'b0, 12);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
